// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two-requester register-file write arbiter with a bulk clear.
// Requester A (ALU writeback) and B (load writeback) share a single registered
// write port; ties go to whichever side was not granted last. A clear request
// zeroes registers 1..31, one per cycle, while requesters are held off.
// Optional feature: define REGARB_DROPCNT_EN to build a saturating 8-bit count
// of dropped R0 writes; without it drop_cnt is tied to 0.
module regfile_wr_arbiter (
  input  logic        elk,
  input  logic        nrst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  // last_grant encoding: 0 = A, 1 = B
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t      r_state;
  logic [4:0]  r_ptr;
  logic        r_last_grant;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_clr_busy;
  logic        r_clr_done;

  logic        w_open;
  logic        w_a_ready;
  logic        w_b_ready;
  logic        w_fire;
  logic [4:0]  w_sel_addr;
  logic [31:0] w_sel_data;

  // Arbitration: requesters see ready only in RUN with no clear pending;
  // on a tie the side not granted last wins.
  always_comb begin
    w_open     = (r_state == RUN) && !clr_req;
    w_a_ready  = w_open && a_valid && (!b_valid || (r_last_grant == GNT_B));
    w_b_ready  = w_open && b_valid && (!a_valid || (r_last_grant == GNT_A));
    w_fire     = w_a_ready || w_b_ready;
    w_sel_addr = w_a_ready ? a_addr : b_addr;
    w_sel_data = w_a_ready ? a_data : b_data;
  end

  assign a_ready  = w_a_ready;
  assign b_ready  = w_b_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

  // RUN/CLEAR FSM with registered write port and clear status outputs.
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      r_state      <= RUN;
      r_ptr        <= 5'd1;
      r_last_grant <= GNT_B;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_wr_data    <= 32'd0;
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // busy stays up through the clr_done cycle, then drops here
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
          if (clr_req) begin
            r_state    <= CLEAR;
            r_ptr      <= 5'd1;
            r_clr_busy <= 1'b1;
            r_wr_en    <= 1'b0;
          end else if (w_fire) begin
            // R0 is hardwired zero: accept the transfer but suppress the write
            r_wr_en      <= (w_sel_addr != 5'd0);
            r_wr_addr    <= w_sel_addr;
            r_wr_data    <= w_sel_data;
            r_last_grant <= w_a_ready ? GNT_A : GNT_B;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_ptr;
          r_wr_data <= 32'd0;
          if (r_ptr == 5'd31) begin
            // last write: pointer parks at 31 instead of wrapping to 0
            r_state    <= RUN;
            r_clr_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 5'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef REGARB_DROPCNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = w_fire && (w_sel_addr == 5'd0);
  assign drop_cnt = r_drop_cnt;

  // Saturating count of accepted-but-dropped R0 writes.
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst)
      r_drop_cnt <= 8'd0;
    else if (w_drop && (r_drop_cnt != 8'hFF))
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. Inputs change 1 time unit after a
// rising edge; ready is sampled 2 units after, registered outputs 1 unit after.
module tb_regfile_wr_arbiter;
  logic        elk = 1'b0;
  logic        nrst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        clr_req, clr_busy, clr_done, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

`ifdef REGARB_DROPCNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
  localparam logic [7:0] EXP_SAT   = 8'd255;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
  localparam logic [7:0] EXP_SAT   = 8'd0;
`endif

  regfile_wr_arbiter dut (
    .elk(elk), .nrst(nrst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drop_cnt(drop_cnt)
  );

  always #5 elk = ~elk;

  task automatic tick();
    @(posedge elk); #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; clr_req = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1;
    tick(); tick();
    nrst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1;
    #2;
    checks++; if ({wr_en, wr_addr, wr_data} !== 38'd0) begin failures++; $display("FAIL reset_wr got=%b/%0d/%h exp=0/0/0", wr_en, wr_addr, wr_data); end
    checks++; if ({clr_busy, clr_done} !== 2'b00) begin failures++; $display("FAIL reset_clr got=%b exp=00", {clr_busy, clr_done}); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    tick(); tick();
    nrst = 0;
  endtask

  // Both requesters held from reset: alternation starts with A.
  task automatic test_tie();
    logic [4:0] exp_addr;
    do_reset();
    a_valid = 1; a_addr = 5'd3; a_data = 32'h3333_0003;
    b_valid = 1; b_addr = 5'd4; b_data = 32'h4444_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_ready[%0d] got=%b exp=%b", i, {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      tick();
      exp_addr = (i % 2 == 0) ? 5'd3 : 5'd4;
      checks++; if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== ((i % 2 == 0) ? 32'h3333_0003 : 32'h4444_0004)) begin failures++; $display("FAIL tie_wr[%0d] got=%b/%0d/%h exp=1/%0d", i, wr_en, wr_addr, wr_data, exp_addr); end
    end
    idle_inputs();
    tick();
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL idle_wr_en got=%b exp=0", wr_en); end
  endtask

  task automatic test_single();
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", a_ready, b_ready); end
    tick();
    a_valid = 0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/deadbeef", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_drop();
    b_valid = 1; b_addr = 5'd0; b_data = 32'h1;
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", b_ready); end
    tick();
    b_valid = 0;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL drop_wr_en got=%b exp=0", wr_en); end
    checks++; if (drop_cnt !== EXP_DROP1) begin failures++; $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, EXP_DROP1); end
  endtask

  task automatic test_clear();
    clr_req = 1; a_valid = 1; a_addr = 5'd7; a_data = 32'h77;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL clr_req_a_ready got=%b exp=0", a_ready); end
    tick();
    clr_req = 0;
    checks++; if (clr_busy !== 1'b1 || wr_en !== 1'b0) begin failures++; $display("FAIL clr_start got=busy%b/wr%b exp=busy1/wr0", clr_busy, wr_en); end
    for (int k = 1; k <= 31; k++) begin
      if (k < 31) begin
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL clr_hold_ready[%0d] got=%b exp=0", k, a_ready); end
      end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== k[4:0] || wr_data !== 32'd0) begin failures++; $display("FAIL clr_wr[%0d] got=%b/%0d/%h exp=1/%0d/0", k, wr_en, wr_addr, wr_data, k); end
      checks++; if (clr_done !== (k == 31) || clr_busy !== 1'b1) begin failures++; $display("FAIL clr_status[%0d] got=done%b/busy%b exp=done%b/busy1", k, clr_done, clr_busy, k == 31); end
    end
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL clr_after_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin failures++; $display("FAIL clr_after_wr got=%b/%0d/%h exp=1/7/77", wr_en, wr_addr, wr_data); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin failures++; $display("FAIL clr_end got=busy%b/done%b exp=00", clr_busy, clr_done); end
  endtask

  task automatic test_reset_mid_clear();
    logic seen_done;
    seen_done = 0;
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (clr_done === 1'b1) seen_done = 1;
    end
    checks++; if (wr_addr !== 5'd9) begin failures++; $display("FAIL midclr_pos got=%0d exp=9", wr_addr); end
    nrst = 1;
    #1;
    checks++; if ({wr_en, wr_addr, wr_data, clr_busy, clr_done} !== 40'd0) begin failures++; $display("FAIL midclr_reset got=%b/%0d/%h/%b/%b exp=all 0", wr_en, wr_addr, wr_data, clr_busy, clr_done); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL midclr_drop got=%0d exp=0", drop_cnt); end
    tick();
    nrst = 0;
    a_valid = 1; a_addr = 5'd12; a_data = 32'hA12;
    b_valid = 1; b_addr = 5'd13; b_data = 32'hB13;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({a_ready, b_ready} !== ((i == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL midclr_arb[%0d] got=%b exp=%b", i, {a_ready, b_ready}, (i == 0) ? 2'b10 : 2'b01); end
      tick();
      if (clr_done === 1'b1 || clr_busy === 1'b1) seen_done = 1;
      checks++; if (wr_en !== 1'b1 || wr_addr !== ((i == 0) ? 5'd12 : 5'd13)) begin failures++; $display("FAIL midclr_wr[%0d] got=%b/%0d exp=1/%0d", i, wr_en, wr_addr, (i == 0) ? 12 : 13); end
    end
    idle_inputs();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clr_done === 1'b1 || clr_busy === 1'b1) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midclr_no_done got=%b exp=0", seen_done); end
  endtask

  task automatic test_saturate();
    do_reset();
    b_valid = 1; b_addr = 5'd0; b_data = 32'h5;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 254) begin
        checks++; if (drop_cnt !== EXP_SAT) begin failures++; $display("FAIL sat_at_255 got=%0d exp=%0d", drop_cnt, EXP_SAT); end
      end
    end
    b_valid = 0;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL sat_wr_en got=%b exp=0", wr_en); end
    checks++; if (drop_cnt !== EXP_SAT) begin failures++; $display("FAIL sat_final got=%0d exp=%0d", drop_cnt, EXP_SAT); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_drop();
    test_clear();
    test_reset_mid_clear();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have port elk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port nrst, input, 1 bit: asynchronous, active-high reset (nrst=1 resets immediately, independent of elk).
REQ-003 SHALL have ports a_valid/a_ready (in/out, 1), a_addr (in, 5), a_data (in, 32): requester A (ALU writeback).
REQ-004 SHALL have ports b_valid/b_ready (in/out, 1), b_addr (in, 5), b_data (in, 32): requester B (load writeback).
REQ-005 SHALL have port clr_req, input, 1 bit: request to zero registers 1..31.
REQ-006 SHALL have ports clr_busy (out, 1) and clr_done (out, 1): clear in progress; one-cycle completion pulse.
REQ-007 SHALL have ports wr_en (out, 1), wr_addr (out, 5), wr_data (out, 32): register-file write port, all registered.
REQ-008 SHALL have port drop_cnt, output, 8 bits: count of dropped R0 writes (see Configuration).

Function
REQ-009 SHALL implement an FSM with states RUN and CLEAR.
REQ-010 In RUN, a transfer on a requester SHALL occur in a cycle where valid=1 and ready=1.
REQ-011 a_ready and b_ready SHALL be combinational; both SHALL be 0 in CLEAR and in any RUN cycle where clr_req=1.
REQ-012 In RUN with only one valid, that requester SHALL be granted (ready=1).
REQ-013 In RUN with both valid, the requester not granted last SHALL win.
REQ-014 A 1-bit last_grant register SHALL update only on an accepted transfer.
REQ-015 An accepted transfer SHALL drive wr_en=1 with its addr and data on the next cycle (latency 1).
REQ-016 In any cycle with no accepted transfer and not in CLEAR, wr_en SHALL be 0 on the next cycle.
REQ-017 A transfer with addr=0 SHALL be accepted (ready=1) but SHALL produce wr_en=0 next cycle (dropped).
REQ-018 clr_req=1 in RUN SHALL move the FSM to CLEAR, load a 5-bit pointer with 1, and assert clr_busy next cycle.
REQ-019 In each CLEAR cycle the block SHALL register wr_en=1, wr_addr=pointer, wr_data=0, then increment the pointer.
REQ-020 After the cycle with pointer=31 the FSM SHALL return to RUN.
REQ-021 clr_done SHALL pulse for one cycle coincident with the wr_addr=31 clear write.
REQ-022 clr_busy SHALL deassert in the following cycle.
REQ-023 A clear SHALL take exactly 31 write cycles, never write address 0, and never wrap the pointer to 0.
REQ-024 clr_req SHALL be ignored while in CLEAR; it SHALL be level-sampled in RUN, so a held clr_req re-triggers after completion.
REQ-025 Requester inputs SHALL be ignored in CLEAR; requesters hold valid until they see ready.

Reset
REQ-026 nrst=1 SHALL force state=RUN, pointer=1, last_grant=B (A wins the first tie), drop_cnt=0, and wr_en/wr_addr/wr_data/clr_busy/clr_done=0.
REQ-027 Reset mid-clear SHALL abort the clear with no clr_done pulse; the clear does not resume.
REQ-028 On reset release, the first accepted transfer SHALL be honoured in the first elk edge after nrst falls.

Configuration
REQ-029 With macro REGARB_DROPCNT_EN defined, drop_cnt SHALL increment by 1 per dropped addr=0 transfer and saturate at 255.
REQ-030 Without REGARB_DROPCNT_EN, drop_cnt SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-031 Bench SHALL apply: a_valid=1, a_addr=5, a_data=32'hDEADBEEF alone -> a_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
REQ-032 Bench SHALL apply: A(addr 3) and B(addr 4) valid and held for 4 cycles after reset -> grants A,B,A,B; wr_addr 3,4,3,4.
REQ-033 Bench SHALL apply: b_valid=1, b_addr=0, b_data=32'h1 -> b_ready=1; next cycle wr_en=0; drop_cnt=1 with REGARB_DROPCNT_EN, 0 without.
REQ-034 Bench SHALL apply: clr_req one-cycle pulse with a_valid=1 -> a_ready=0 that cycle; 31 consecutive writes addr 1..31, data 0; clr_done with addr 31; then A accepted.
REQ-035 Bench SHALL apply: nrst=1 during clear at pointer=10 -> all outputs 0 immediately, no clr_done; after release, normal RUN arbitration.
REQ-036 Bench SHALL apply: 300 addr-0 transfers with REGARB_DROPCNT_EN -> drop_cnt saturates at 255.
